// File: rtl/triangle_pwm_pkg.sv
// Shared definitions for the centre-aligned PWM with dead-time:
// default widths and the gate-drive FSM state encoding.
package triangle_pwm_pkg;

  localparam int DATA_WIDTH_DEF = 12;
  localparam int DT_WIDTH_DEF   = 8;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    H_ON = 2'd1,
    L_ON = 2'd2,
    DEAD = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// Complementary gate driver: turns the raw compare into a high/low pair
// separated by deadtime_active+1 cycles with both gates low.
module pwm_deadtime_fsm
  import triangle_pwm_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                ref_clk,
  input  logic                rstn,
  input  logic                raw,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] deadtime_active,
  output logic                pwm_h,
  output logic                pwm_l
);

  pwm_state_e          state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                pwm_h_q, pwm_l_q;

  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= OFF;
      cnt_q   <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_h_q <= (state_d == H_ON);
      pwm_l_q <= (state_d == L_ON);
    end
  end

  // The DEAD exit side is chosen from raw in the exit cycle only, so a
  // compare glitch inside the dead interval cannot select the wrong gate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          state_d = DEAD;
          cnt_d   = deadtime_active;
        end
        H_ON: begin
          if (!raw) begin
            state_d = DEAD;
            cnt_d   = deadtime_active;
          end
        end
        L_ON: begin
          if (raw) begin
            state_d = DEAD;
            cnt_d   = deadtime_active;
          end
        end
        DEAD: begin
          if (cnt_q == '0) state_d = raw ? H_ON : L_ON;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = OFF;
      endcase
    end
  end

  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;

endmodule

// File: rtl/triangle_pwm_deadtime.sv
// Centre-aligned PWM from a triangle carrier: turning-point detection,
// valley-committed duty/dead-time shadow registers, compare and gate drive.
module triangle_pwm_deadtime
  import triangle_pwm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DT_WIDTH   = DT_WIDTH_DEF
) (
  input  logic                  ref_clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] triangle_wave,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] duty_in,
  input  logic                  duty_load,
  input  logic [DT_WIDTH-1:0]   deadtime,
  output logic                  pwm_h,
  output logic                  pwm_l,
  output logic                  valley,
  output logic                  peak,
  output logic [DATA_WIDTH-1:0] duty_active,
  output logic                  load_pending
);

  logic [DATA_WIDTH-1:0] tri_q;
  logic                  dir_q, dir_d;
  logic                  valley_q, valley_d;
  logic                  peak_q, peak_d;
  logic                  rising, falling;

  logic [DATA_WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic [DATA_WIDTH-1:0] duty_act_q, duty_act_d;
  logic [DT_WIDTH-1:0]   dt_act_q, dt_act_d;
  logic                  load_pend_q, load_pend_d;
  logic                  raw;

  // Carrier stage: dir is 1 while rising; a flat sample keeps the direction.
  assign rising   = (triangle_wave > tri_q);
  assign falling  = (triangle_wave < tri_q);
  assign dir_d    = rising ? 1'b1 : (falling ? 1'b0 : dir_q);
  assign valley_d = !dir_q && rising;
  assign peak_d   = dir_q && falling;

  // Shadow registers: a load coincident with a valley commits the old
  // pending value and keeps the new one pending for the next valley.
  always_comb begin
    duty_pend_d = duty_pend_q;
    duty_act_d  = duty_act_q;
    dt_act_d    = dt_act_q;
    load_pend_d = load_pend_q;
    if (valley_q) begin
      duty_act_d  = duty_pend_q;
      dt_act_d    = deadtime;
      load_pend_d = 1'b0;
    end
    if (duty_load) begin
      duty_pend_d = duty_in;
      load_pend_d = 1'b1;
    end
  end

  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) begin
      tri_q       <= '0;
      dir_q       <= 1'b1;
      valley_q    <= 1'b0;
      peak_q      <= 1'b0;
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      dt_act_q    <= '0;
      load_pend_q <= 1'b0;
    end else begin
      tri_q       <= triangle_wave;
      dir_q       <= dir_d;
      valley_q    <= valley_d;
      peak_q      <= peak_d;
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      dt_act_q    <= dt_act_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign raw = (tri_q < duty_act_q);

  pwm_deadtime_fsm #(
    .DT_WIDTH (DT_WIDTH)
  ) u_fsm (
    .ref_clk         (ref_clk),
    .rstn            (rstn),
    .raw             (raw),
    .enable          (enable),
    .deadtime_active (dt_act_q),
    .pwm_h           (pwm_h),
    .pwm_l           (pwm_l)
  );

  assign valley       = valley_q;
  assign peak         = peak_q;
  assign duty_active  = duty_act_q;
  assign load_pending = load_pend_q;

endmodule
